// File: rtl/csr_mmio_pkg.sv
// Package for the MMIO CSR bridge.
// Holds the fixed DWORD address map, the read-request and CSR structs,
// the perf counter type, and the app CSR address decoder.
package csr_mmio_pkg;
   localparam int          NUM_APP_CSRS  = 8;
   localparam int          APP_IDX_W     = $clog2(NUM_APP_CSRS);

   localparam logic [15:0] CSR_DFH       = 16'h0000;
   localparam logic [15:0] CSR_AFU_ID_L  = 16'h0002;
   localparam logic [15:0] CSR_AFU_ID_H  = 16'h0004;
   localparam logic [15:0] CSR_PERF_RD   = 16'h0010;
   localparam logic [15:0] CSR_PERF_WR   = 16'h0012;
   localparam logic [15:0] CSR_PERF_DROP = 16'h0014;
   localparam logic [15:0] APP_BASE_DFLT = 16'h0040;

   typedef logic [39:0] t_csr_mgr_counter;

   typedef struct packed {
      logic [8:0]  tid;
      logic [15:0] addr;
   } t_csr_rd_req;

   typedef struct packed {
      logic [63:0] data;
   } t_cpu_rd_csr;

   typedef struct packed {
      logic        en;
      logic [63:0] data;
   } t_cpu_wr_csr;

   typedef struct packed {
      logic                 hit;
      logic [APP_IDX_W-1:0] idx;
   } t_app_idx;

   // App CSR i lives at base+2*i; odd offsets and indices past the
   // last CSR are misses.
   function automatic t_app_idx csr_app_index(input logic [15:0] addr,
                                              input logic [15:0] base = APP_BASE_DFLT);
      logic [15:0] off;
      t_app_idx    r;
      off   = addr - base;
      r.hit = (addr >= base) && !off[0] && (off[15:1] < 15'(NUM_APP_CSRS));
      r.idx = off[APP_IDX_W:1];
      return r;
   endfunction
endpackage

// File: rtl/app_csrs.sv
// Application CSR bundle.
//  afu_id       128-bit AFU identifier (app -> bridge)
//  cpu_rd_csrs  per-CSR read data      (app -> bridge)
//  cpu_wr_csrs  per-CSR write en/data  (bridge -> app)
// Modport csr is the bridge side, app the application side.
interface app_csrs;
   import csr_mmio_pkg::*;
   logic [127:0] afu_id;
   t_cpu_rd_csr  cpu_rd_csrs [NUM_APP_CSRS];
   t_cpu_wr_csr  cpu_wr_csrs [NUM_APP_CSRS];

   modport csr (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
   modport app (output afu_id, output cpu_rd_csrs, input cpu_wr_csrs);
endinterface

// File: rtl/csr_mmio_rd_fifo.sv
// Synchronous FIFO of read requests.
//  i_push/i_din   enqueue; ignored while o_full
//  i_pop          dequeue; ignored while o_empty
//  o_dout         head entry (valid when !o_empty)
//  o_full         registered, count==DEPTH
//  o_empty        count==0
// DEPTH must be a power of 2 so the pointers wrap naturally.
module csr_mmio_rd_fifo
   import csr_mmio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  t_csr_rd_req i_din,
   input  logic        i_pop,
   output t_csr_rd_req o_dout,
   output logic        o_full,
   output logic        o_empty
);
   localparam int AW = $clog2(DEPTH);

   t_csr_rd_req r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          w_push, w_pop;
   logic [AW:0]   w_count_nxt;

   // Push is gated by the registered full flag, so a pop in the same
   // cycle never makes room for the arriving request.
   assign w_push  = i_push && !r_full;
   assign w_pop   = i_pop && (r_count != '0);
   assign o_dout  = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
      else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end
endmodule

// File: rtl/app_csr_mmio_ctrl.sv
// Host MMIO to application CSR bridge.
//  mmio_wr_*   host writes -> one-cycle cpu_wr_csrs[i].en pulse, data held
//  mmio_rd_*   host reads  -> queued, looked up, returned in order on rsp_*
//  rsp_ready   backpressure; the lookup stage only advances while it is high
//  rd_q_full   read FIFO full (arriving read is dropped)
//  rd_drop_err sticky drop flag
//  csrs        app_csrs.csr bundle
// Optional: CSR_MMIO_PERF_CNT_EN adds read/write/drop counters at
// 0x10/0x12/0x14; without it those addresses read as zero.
module app_csr_mmio_ctrl
   import csr_mmio_pkg::*;
#(
   parameter int          RD_Q_DEPTH = 4,
   parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_0001,
   parameter logic [15:0] APP_BASE   = APP_BASE_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mmio_wr_valid,
   input  logic [15:0] mmio_wr_addr,
   input  logic [63:0] mmio_wr_data,
   input  logic        mmio_rd_valid,
   input  logic [15:0] mmio_rd_addr,
   input  logic [8:0]  mmio_rd_tid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [8:0]  rsp_tid,
   output logic [63:0] rsp_data,
   output logic        rd_q_full,
   output logic        rd_drop_err,
   app_csrs.csr        csrs
);
   t_csr_rd_req w_head;
   logic        w_full, w_empty, w_pop;
   t_app_idx    w_hd_idx, w_wr_idx;
   logic [63:0] w_lk_data;

   logic                             r_rsp_valid;
   logic [8:0]                       r_rsp_tid;
   logic [63:0]                      r_rsp_data;
   logic                             r_drop_err;
   logic [NUM_APP_CSRS-1:0]          r_wr_en;
   logic [NUM_APP_CSRS-1:0][63:0]    r_wr_data;

   // LOOKUP stage is the FIFO head: it is decoded and sampled in the
   // cycle it moves into RSP, which only happens while rsp_ready is high.
   // That keeps queued reads in the FIFO under backpressure.
   assign w_pop = rsp_ready && !w_empty;

   csr_mmio_rd_fifo #(.DEPTH(RD_Q_DEPTH)) u_rd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (mmio_rd_valid),
      .i_din   ('{tid: mmio_rd_tid, addr: mmio_rd_addr}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef CSR_MMIO_PERF_CNT_EN
   t_csr_mgr_counter r_cnt_rd, r_cnt_wr, r_cnt_drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt_rd   <= '0;
         r_cnt_wr   <= '0;
         r_cnt_drop <= '0;
      end else begin
         if (mmio_rd_valid && !w_full) r_cnt_rd   <= r_cnt_rd + 1'b1;
         if (mmio_wr_valid)            r_cnt_wr   <= r_cnt_wr + 1'b1;
         if (mmio_rd_valid && w_full)  r_cnt_drop <= r_cnt_drop + 1'b1;
      end
   end
`endif

   assign w_hd_idx = csr_app_index(w_head.addr, APP_BASE);

   always_comb begin
      w_lk_data = 64'h0;
      case (w_head.addr)
         CSR_DFH:       w_lk_data = DFH_VALUE;
         CSR_AFU_ID_L:  w_lk_data = csrs.afu_id[63:0];
         CSR_AFU_ID_H:  w_lk_data = csrs.afu_id[127:64];
`ifdef CSR_MMIO_PERF_CNT_EN
         CSR_PERF_RD:   w_lk_data = {24'h0, r_cnt_rd};
         CSR_PERF_WR:   w_lk_data = {24'h0, r_cnt_wr};
         CSR_PERF_DROP: w_lk_data = {24'h0, r_cnt_drop};
`endif
         default: if (w_hd_idx.hit) w_lk_data = csrs.cpu_rd_csrs[w_hd_idx.idx].data;
      endcase
   end

   // RSP register: loads (or empties) only while the consumer is ready,
   // so a waiting response is held stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
      end else if (rsp_ready) begin
         r_rsp_valid <= !w_empty;
         if (!w_empty) begin
            r_rsp_tid  <= w_head.tid;
            r_rsp_data <= w_lk_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_drop_err <= 1'b0;
      else if (mmio_rd_valid && w_full) r_drop_err <= 1'b1;
   end

   assign w_wr_idx = csr_app_index(mmio_wr_addr, APP_BASE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_en   <= '0;
         r_wr_data <= '0;
      end else begin
         for (int i = 0; i < NUM_APP_CSRS; i++) begin
            r_wr_en[i] <= mmio_wr_valid && w_wr_idx.hit && (w_wr_idx.idx == APP_IDX_W'(i));
            if (mmio_wr_valid && w_wr_idx.hit && (w_wr_idx.idx == APP_IDX_W'(i)))
               r_wr_data[i] <= mmio_wr_data;
         end
      end
   end

   for (genvar g = 0; g < NUM_APP_CSRS; g++) begin : g_wr
      assign csrs.cpu_wr_csrs[g].en   = r_wr_en[g];
      assign csrs.cpu_wr_csrs[g].data = r_wr_data[g];
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_tid     = r_rsp_tid;
   assign rsp_data    = r_rsp_data;
   assign rd_q_full   = w_full;
   assign rd_drop_err = r_drop_err;
endmodule

// File: tb/tb_app_csr_mmio_ctrl.sv
// Directed bench for app_csr_mmio_ctrl. Inputs change 1ns after the
// rising edge; outputs are checked at that same point.
module tb_app_csr_mmio_ctrl;
   import csr_mmio_pkg::*;

   localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;
   localparam logic [63:0] C0  = 64'hC0DE_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mmio_wr_valid;
   logic [15:0] mmio_wr_addr;
   logic [63:0] mmio_wr_data;
   logic        mmio_rd_valid;
   logic [15:0] mmio_rd_addr;
   logic [8:0]  mmio_rd_tid;
   logic        rsp_valid, rsp_ready;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic        rd_q_full, rd_drop_err;
   logic [7:0]  en_vec;

   int n_vec = 0;
   int n_err = 0;

   app_csrs csrs_if ();

   app_csr_mmio_ctrl #(.RD_Q_DEPTH(4), .DFH_VALUE(DFH), .APP_BASE(16'h0040)) dut (
      .clk(clk), .reset(reset),
      .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
      .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_tid(mmio_rd_tid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .rd_q_full(rd_q_full), .rd_drop_err(rd_drop_err), .csrs(csrs_if)
   );

   always #5 clk = ~clk;

   for (genvar g = 0; g < 8; g++) begin : g_en
      assign en_vec[g] = csrs_if.cpu_wr_csrs[g].en;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio_wr_valid = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
      step();
      mmio_wr_valid = 1'b0;
   endtask

   task automatic rd_push(input logic [15:0] a, input logic [8:0] t);
      mmio_rd_valid = 1'b1; mmio_rd_addr = a; mmio_rd_tid = t;
      step();
      mmio_rd_valid = 1'b0;
   endtask

   // Single read with the pipeline idle and rsp_ready high: response at N+2.
   task automatic do_read(input string tag, input logic [15:0] a, input logic [8:0] t,
                          input logic [63:0] exp);
      rsp_ready = 1'b1;
      rd_push(a, t);
      chk({tag, "_lat1"}, {63'h0, rsp_valid}, 64'h0);
      step();
      chk({tag, "_vld"}, {63'h0, rsp_valid}, 64'h1);
      chk({tag, "_tid"}, {55'h0, rsp_tid}, {55'h0, t});
      chk({tag, "_data"}, rsp_data, exp);
      step();
      chk({tag, "_idle"}, {63'h0, rsp_valid}, 64'h0);
   endtask

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0;
      mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0;
      csrs_if.afu_id = 128'h1122334455667788_9900AABBCCDDEEFF;
      for (int i = 0; i < 8; i++) csrs_if.cpu_rd_csrs[i].data = C0 | 64'(i);
      csrs_if.cpu_rd_csrs[5].data = 64'hABCD;
      step(); step();

      // reset values
      chk("rst_valid", {63'h0, rsp_valid}, 64'h0);
      chk("rst_tid", {55'h0, rsp_tid}, 64'h0);
      chk("rst_data", rsp_data, 64'h0);
      chk("rst_full", {63'h0, rd_q_full}, 64'h0);
      chk("rst_drop", {63'h0, rd_drop_err}, 64'h0);
      chk("rst_en", {56'h0, en_vec}, 64'h0);
      chk("rst_wdata", csrs_if.cpu_wr_csrs[3].data, 64'h0);
      reset = 1'b0;
      step();

      // write decode: one-cycle pulse on CSR 3, data held
      wr(16'h0046, 64'h55);
      chk("wr_en_pulse", {56'h0, en_vec}, 64'h08);
      chk("wr_data", csrs_if.cpu_wr_csrs[3].data, 64'h55);
      step();
      chk("wr_en_off", {56'h0, en_vec}, 64'h0);
      chk("wr_data_hold", csrs_if.cpu_wr_csrs[3].data, 64'h55);

      // ignored write addresses: odd, unaligned app offset, past last CSR
      wr(16'h0001, 64'h1);
      chk("wr_0x01", {56'h0, en_vec}, 64'h0);
      wr(16'h0047, 64'h2);
      chk("wr_0x47", {56'h0, en_vec}, 64'h0);
      wr(16'h0050, 64'h3);
      chk("wr_0x50", {56'h0, en_vec}, 64'h0);
      chk("wr_ign_hold", csrs_if.cpu_wr_csrs[3].data, 64'h55);

      // basic read latency
      do_read("rd_csr5", 16'h004A, 9'h1F0, 64'hABCD);

      // back-to-back reads, one response per cycle
      rsp_ready = 1'b1;
      rd_push(16'h0004, 9'd10);
      chk("b2b_lat", {63'h0, rsp_valid}, 64'h0);
      rd_push(16'h0002, 9'd11);
      chk("b2b0_tid", {55'h0, rsp_tid}, 64'd10);
      chk("b2b0_data", rsp_data, 64'h1122334455667788);
      rd_push(16'h03FF, 9'd12);
      chk("b2b1_tid", {55'h0, rsp_tid}, 64'd11);
      chk("b2b1_data", rsp_data, 64'h9900AABBCCDDEEFF);
      step();
      chk("b2b2_vld", {63'h0, rsp_valid}, 64'h1);
      chk("b2b2_tid", {55'h0, rsp_tid}, 64'd12);
      chk("b2b2_data", rsp_data, 64'h0);
      step();
      chk("b2b_idle", {63'h0, rsp_valid}, 64'h0);

      // response held stable under backpressure
      rd_push(16'h0048, 9'h33);
      step();
      rsp_ready = 1'b0;
      step(); step();
      chk("hold_vld", {63'h0, rsp_valid}, 64'h1);
      chk("hold_tid", {55'h0, rsp_tid}, 64'h33);
      chk("hold_data", rsp_data, C0 | 64'd4);
      rsp_ready = 1'b1;
      step();
      chk("hold_done", {63'h0, rsp_valid}, 64'h0);

      // simultaneous read and write
      mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0040; mmio_wr_data = 64'h77;
      mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0040; mmio_rd_tid = 9'h0AA;
      step();
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
      chk("rw_en", {56'h0, en_vec}, 64'h01);
      step();
      chk("rw_rsp_tid", {55'h0, rsp_tid}, 64'h0AA);
      chk("rw_rsp_data", rsp_data, C0);
      step();

      // fill FIFO, drop 5th, release in order
      rsp_ready = 1'b0;
      for (int t = 1; t <= 3; t++) rd_push(16'h0000, 9'(t));
      chk("fill3_full", {63'h0, rd_q_full}, 64'h0);
      rd_push(16'h0000, 9'd4);
      chk("fill4_full", {63'h0, rd_q_full}, 64'h1);
      rd_push(16'h0000, 9'd5);
      chk("drop_err", {63'h0, rd_drop_err}, 64'h1);
      chk("drop_full", {63'h0, rd_q_full}, 64'h1);
      chk("drop_novld", {63'h0, rsp_valid}, 64'h0);
      rsp_ready = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         step();
         chk("drain_vld", {63'h0, rsp_valid}, 64'h1);
         chk("drain_tid", {55'h0, rsp_tid}, 64'(t));
         chk("drain_data", rsp_data, DFH);
      end
      chk("drain_full", {63'h0, rd_q_full}, 64'h0);
      step();
      chk("drain_idle", {63'h0, rsp_valid}, 64'h0);
      chk("drop_sticky", {63'h0, rd_drop_err}, 64'h1);

      // reset with queued reads and a pending write pulse
      rsp_ready = 1'b0;
      for (int t = 20; t < 23; t++) rd_push(16'h0000, 9'(t));
      reset = 1'b1;
      mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0042; mmio_wr_data = 64'h99;
      step();
      mmio_wr_valid = 1'b0;
      reset = 1'b0;
      rsp_ready = 1'b1;
      chk("mrst_en", {56'h0, en_vec}, 64'h0);
      chk("mrst_wdata", csrs_if.cpu_wr_csrs[3].data, 64'h0);
      chk("mrst_drop", {63'h0, rd_drop_err}, 64'h0);
      chk("mrst_tid", {55'h0, rsp_tid}, 64'h0);
      chk("mrst_data", rsp_data, 64'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("mrst_norsp", {63'h0, rsp_valid}, 64'h0);
         chk("mrst_full", {63'h0, rd_q_full}, 64'h0);
      end
      do_read("post_rst", 16'h004A, 9'h077, 64'hABCD);

      // perf counters: 7 reads accepted, 2 writes, 1 drop since reset
      reset = 1'b1; step(); reset = 1'b0; step();
      rsp_ready = 1'b0;
      for (int t = 1; t <= 4; t++) rd_push(16'h0000, 9'(t));
      rd_push(16'h0000, 9'd5);
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) step();
      wr(16'h0001, 64'h0);
      wr(16'h0040, 64'h5);
      do_read("pc_r5", 16'h0000, 9'd6, DFH);
      do_read("pc_r6", 16'h0000, 9'd7, DFH);
`ifdef CSR_MMIO_PERF_CNT_EN
      do_read("perf_rd", 16'h0010, 9'd8, 64'd7);
      do_read("perf_wr", 16'h0012, 9'd9, 64'd2);
      do_read("perf_drop", 16'h0014, 9'd10, 64'd1);
`else
      do_read("perf_rd", 16'h0010, 9'd8, 64'd0);
      do_read("perf_wr", 16'h0012, 9'd9, 64'd0);
      do_read("perf_drop", 16'h0014, 9'd10, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
